// File: rtl/lcd_fb_pkg.sv
// lcd_fb_pkg: FSM encoding and sizing helper shared by the LCD frame buffer files.
package lcd_fb_pkg;
   typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} fb_state_e;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/lcd_fb_bank_ram.sv
// lcd_fb_bank_ram: simple dual-port pixel RAM, one write port and one registered read port.
module lcd_fb_bank_ram
   import lcd_fb_pkg::*;
#(
   parameter int DEPTH = 1920,
   parameter int PIX_W = 4,
   parameter int AW = clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             re,
   input  logic [AW-1:0]    rd_addr,
   output logic [PIX_W-1:0] rd_data
);
   logic [PIX_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[wr_addr] <= wr_data;
   // Only the output register is reset; array contents come from the fill engine.
   always_ff @(posedge clk or posedge rst)
      if (rst) rd_data <= '0;
      else if (re) rd_data <= mem[rd_addr];
endmodule

// File: rtl/lcd_frame_buffer_ctrl.sv
// lcd_frame_buffer_ctrl: LCD pixel store with handshaked writes, fill engine and registered reads.
// Define LCD_FB_DOUBLE_BUF_EN for two banks with swap_req/frame_sync controlled page flipping.
module lcd_frame_buffer_ctrl
   import lcd_fb_pkg::*;
#(
   parameter int WIDTH   = 60,
   parameter int HEIGHT  = 32,
   parameter int PIX_W   = 4,
   parameter int COORD_W = 6
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [COORD_W-1:0] wr_x,
   input  logic [COORD_W-1:0] wr_y,
   input  logic [PIX_W-1:0]   wr_data,
   output logic               wr_err,
   input  logic               fill_start,
   input  logic [PIX_W-1:0]   fill_data,
   output logic               fill_busy,
   output logic               fill_done,
   input  logic               rd_en,
   input  logic [COORD_W-1:0] rd_x,
   input  logic [COORD_W-1:0] rd_y,
   output logic [PIX_W-1:0]   rd_data,
`ifdef LCD_FB_DOUBLE_BUF_EN
   input  logic               swap_req,
   input  logic               frame_sync,
   output logic               front_bank,
   output logic               swap_pending,
`endif
   output logic               rd_valid
);
   localparam int DEPTH = WIDTH * HEIGHT;
   localparam int AW = clog2(DEPTH);
   fb_state_e state, state_nx;
   logic [AW-1:0] fill_cnt, wr_addr, rd_addr, ram_waddr;
   logic [PIX_W-1:0] fill_val, ram_wdata, ram_q;
   logic wr_in, rd_in, wr_acc, fill_last, ram_we, ram_re, rd_oor;
   function automatic logic [AW-1:0] xy_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
      return AW'(y) * AW'(WIDTH) + AW'(x);
   endfunction
   // Range is judged on the raw coordinates so a wrapped address can never alias a real pixel.
   assign wr_in = int'(wr_x) < WIDTH && int'(wr_y) < HEIGHT;
   assign rd_in = int'(rd_x) < WIDTH && int'(rd_y) < HEIGHT;
   assign wr_addr = xy_addr(wr_x, wr_y);
   assign rd_addr = xy_addr(rd_x, rd_y);
   assign wr_acc = wr_valid && wr_ready;
   assign fill_last = fill_cnt == AW'(DEPTH - 1);
   assign ram_re = rd_en && rd_in;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ST_IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state == ST_IDLE ? (fill_start ? ST_FILL : ST_IDLE) : (fill_last ? ST_IDLE : ST_FILL);
   end
   always_comb begin
      wr_ready = state == ST_IDLE && !rst;
      fill_busy = state == ST_FILL;
      ram_we = fill_busy || (wr_acc && wr_in);
      ram_waddr = fill_busy ? fill_cnt : wr_addr;
      ram_wdata = fill_busy ? fill_val : wr_data;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fill_cnt <= '0;
         fill_val <= '0;
         wr_err <= 1'b0;
         fill_done <= 1'b0;
         rd_valid <= 1'b0;
         rd_oor <= 1'b0;
      end else begin
         fill_cnt <= state == ST_FILL ? fill_cnt + 1'b1 : '0;
         if (state == ST_IDLE && fill_start) fill_val <= fill_data;
         wr_err <= wr_acc && !wr_in;
         fill_done <= state == ST_FILL && fill_last;
         rd_valid <= rd_en;
         if (rd_en) rd_oor <= !rd_in;
      end
   assign rd_data = rd_oor ? '0 : ram_q;
`ifdef LCD_FB_DOUBLE_BUF_EN
   logic rd_bank;
   logic [PIX_W-1:0] q0, q1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         front_bank <= 1'b0;
         swap_pending <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         if (rd_en) rd_bank <= front_bank;
         if (frame_sync && (swap_pending || swap_req)) begin
            front_bank <= !front_bank;
            swap_pending <= 1'b0;
         end else if (swap_req) swap_pending <= 1'b1;
      end
   // Writes and fill always land in the back bank, i.e. the one not being scanned out.
   lcd_fb_bank_ram #(.DEPTH(DEPTH), .PIX_W(PIX_W), .AW(AW)) u_bank0 (
      .clk(clk), .rst(rst), .we(ram_we && front_bank), .wr_addr(ram_waddr), .wr_data(ram_wdata),
      .re(ram_re && !front_bank), .rd_addr(rd_addr), .rd_data(q0)
   );
   lcd_fb_bank_ram #(.DEPTH(DEPTH), .PIX_W(PIX_W), .AW(AW)) u_bank1 (
      .clk(clk), .rst(rst), .we(ram_we && !front_bank), .wr_addr(ram_waddr), .wr_data(ram_wdata),
      .re(ram_re && front_bank), .rd_addr(rd_addr), .rd_data(q1)
   );
   assign ram_q = rd_bank ? q1 : q0;
`else
   lcd_fb_bank_ram #(.DEPTH(DEPTH), .PIX_W(PIX_W), .AW(AW)) u_bank0 (
      .clk(clk), .rst(rst), .we(ram_we), .wr_addr(ram_waddr), .wr_data(ram_wdata),
      .re(ram_re), .rd_addr(rd_addr), .rd_data(ram_q)
   );
`endif
endmodule

// File: tb/tb_lcd_frame_buffer_ctrl.sv
// tb_lcd_frame_buffer_ctrl: directed stimulus with a read-data scoreboard for lcd_frame_buffer_ctrl.
module tb_lcd_frame_buffer_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic wr_valid = 0, wr_ready, wr_err, fill_start = 0, fill_busy, fill_done, rd_en = 0, rd_valid;
   logic [5:0] wr_x = 0, wr_y = 0, rd_x = 0, rd_y = 0;
   logic [3:0] wr_data = 0, fill_data = 0, rd_data;
`ifdef LCD_FB_DOUBLE_BUF_EN
   logic swap_req = 0, frame_sync = 0, front_bank, swap_pending;
`endif
   int n_checks = 0, n_fail = 0;
   logic [3:0] exp_q[$];

   lcd_frame_buffer_ctrl dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .wr_err(wr_err), .fill_start(fill_start), .fill_data(fill_data),
      .fill_busy(fill_busy), .fill_done(fill_done), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
      .rd_data(rd_data),
`ifdef LCD_FB_DOUBLE_BUF_EN
      .swap_req(swap_req), .frame_sync(frame_sync), .front_bank(front_bank), .swap_pending(swap_pending),
`endif
      .rd_valid(rd_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (rd_valid) begin
         if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
         else chk("rd_data", {28'b0, rd_data}, {28'b0, exp_q.pop_front()});
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int x, input int y, input logic [3:0] d);
      wr_valid = 1; wr_x = 6'(x); wr_y = 6'(y); wr_data = d;
      tick();
      wr_valid = 0;
   endtask

   task automatic rd(input int x, input int y, input logic [3:0] e);
      rd_en = 1; rd_x = 6'(x); rd_y = 6'(y);
      exp_q.push_back(e);
      tick();
      rd_en = 0;
   endtask

   task automatic start_fill(input logic [3:0] d);
      fill_start = 1; fill_data = d;
      tick();
      fill_start = 0;
   endtask

   task automatic wait_fill();
      int n = 0;
      while (!fill_done && n < 3000) begin tick(); n++; end
      chk("fill_done_seen", fill_done, 1);
      tick();
   endtask

   initial begin
      repeat (2) tick();
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_fill_busy", fill_busy, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_wr_err", wr_err, 0);
      chk("rst_fill_done", fill_done, 0);
      rst = 0;
      tick();
      chk("ready_after_rst", wr_ready, 1);
`ifdef LCD_FB_DOUBLE_BUF_EN
      chk("rst_front_bank", front_bank, 0);
      chk("rst_swap_pending", swap_pending, 0);
      start_fill(4'h1);
      wait_fill();
      swap_req = 1; frame_sync = 1;
      tick();
      swap_req = 0; frame_sync = 0;
      chk("swap_same_cycle", front_bank, 1);
      start_fill(4'h2);
      wait_fill();
      swap_req = 1; frame_sync = 1;
      tick();
      swap_req = 0; frame_sync = 0;
      chk("swap_back", front_bank, 0);
      wr(0, 0, 4'h5);
      rd(0, 0, 4'h2);
      swap_req = 1;
      tick();
      swap_req = 0;
      chk("pending_set", swap_pending, 1);
      chk("front_held", front_bank, 0);
      frame_sync = 1;
      tick();
      frame_sync = 0;
      chk("front_after_sync", front_bank, 1);
      chk("pending_clr", swap_pending, 0);
      rd(0, 0, 4'h5);
      rd(1, 0, 4'h1);
`else
      wr(5, 3, 4'hA);
      rd(5, 3, 4'hA);
      begin
         int n = 0, bad_ready = 0, early_done = 0;
         start_fill(4'h7);
         while (fill_busy && n < 3000) begin
            if (wr_ready) bad_ready++;
            if (fill_done) early_done++;
            fill_start = n == 10; fill_data = 4'h3;
            n++;
            tick();
         end
         fill_start = 0;
         chk("fill_cycles", n, 1920);
         chk("fill_ready_low", bad_ready, 0);
         chk("fill_done_early", early_done, 0);
         chk("fill_done_pulse", fill_done, 1);
         tick();
         chk("fill_done_1cyc", fill_done, 0);
         chk("fill_restart", fill_busy, 0);
      end
      rd(59, 31, 4'h7);
      rd(0, 0, 4'h7);
      rd(5, 3, 4'h7);
      wr(60, 0, 4'hF);
      chk("wr_err_x", wr_err, 1);
      tick();
      chk("wr_err_clr", wr_err, 0);
      wr(0, 32, 4'hF);
      chk("wr_err_y", wr_err, 1);
      wr(1, 0, 4'h2);
      chk("wr_err_inrange", wr_err, 0);
      rd(0, 0, 4'h7);
      rd(0, 1, 4'h7);
      rd(60, 0, 4'h0);
      rd(0, 32, 4'h0);
      rd(1, 0, 4'h2);
      repeat (3) tick();
      chk("rd_hold", rd_data, 4'h2);
      wr_valid = 1; wr_x = 1; wr_y = 1; wr_data = 4'h3;
      start_fill(4'h0);
      wr_valid = 0;
      wait_fill();
      rd(1, 1, 4'h0);
      wr_valid = 1; wr_x = 2; wr_y = 2; wr_data = 4'h9;
      rd(2, 2, 4'h0);
      wr_valid = 0;
      rd(2, 2, 4'h9);
      begin
         int dn = 0, bz = 0;
         start_fill(4'h5);
         repeat (100) tick();
         rst = 1;
         #1;
         chk("midrst_busy", fill_busy, 0);
         chk("midrst_ready", wr_ready, 0);
         tick();
         rst = 0;
         tick();
         chk("postrst_busy", fill_busy, 0);
         chk("postrst_ready", wr_ready, 1);
         repeat (2000) begin
            if (fill_done) dn++;
            if (fill_busy) bz++;
            tick();
         end
         chk("postrst_no_done", dn, 0);
         chk("postrst_no_busy", bz, 0);
      end
      rd(0, 0, 4'h5);
      rd(1, 1, 4'h5);
      rd(59, 31, 4'h0);
`endif
      repeat (3) tick();
      chk("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
